// File: rtl/stack_data_memory_pkg.sv
// Shared encodings for the stack data memory: request opcodes, sequencer states
// and default widths.
package stack_mem_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CCR_W  = 3;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_INT  = 3'd5;
  localparam logic [2:0] OP_RTI  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_PUSH_CCR,
    ST_POP_0,
    ST_POP_1,
    ST_POP_2,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/stack_data_memory_if.sv
// MEM-stage bus between the EX/MEM register (master) and the stack data memory (slave).
interface stack_data_memory_if #(
  parameter int ADDR_W = stack_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W = stack_mem_pkg::DEF_DATA_W,
  parameter int CCR_W  = stack_mem_pkg::DEF_CCR_W
);
  logic                  op_valid;
  logic [2:0]            op;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wr_data;
  logic [2*DATA_W-1:0]   pc;
  logic [CCR_W-1:0]      ccr;
  logic [DATA_W-1:0]     rd_data;
  logic [2*DATA_W-1:0]   pc_out;
  logic [CCR_W-1:0]      ccr_out;
  logic                  frame_done;
  logic                  busy;
  logic [ADDR_W-1:0]     sp_out;
  logic                  stack_ovf;
  logic                  stack_unf;

  modport master (
    output op_valid, op, mem_rd, mem_wr, addr, wr_data, pc, ccr,
    input  rd_data, pc_out, ccr_out, frame_done, busy, sp_out, stack_ovf, stack_unf
  );

  modport slave (
    input  op_valid, op, mem_rd, mem_wr, addr, wr_data, pc, ccr,
    output rd_data, pc_out, ccr_out, frame_done, busy, sp_out, stack_ovf, stack_unf
  );
endinterface

// File: rtl/stack_data_memory_sp_ram.sv
// Single-port synchronous RAM; write has priority, read data registered and held
// until the next read.
module sp_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/stack_data_memory.sv
// MEM-stage data RAM with hardware stack pointer and CALL/RET/INT/RTI frame sequencer.
// Define STACK_BOUNDS_CHECK_EN to enable overflow/underflow suppression and sticky flags.
//
// state       | meaning
// ST_IDLE     | data ops, single PUSH/POP, accept frame requests
// ST_PUSH_HI  | push pc[hi]
// ST_PUSH_LO  | push pc[lo]; CALL ends here
// ST_PUSH_CCR | push zero-extended ccr (INT only)
// ST_POP_0    | pop first word (RET: pc lo, RTI: ccr)
// ST_POP_1    | pop second word, latch first
// ST_POP_2    | pop pc hi, latch pc lo (RTI only)
// ST_CAPTURE  | assemble pc_out/ccr_out, pulse frame_done
module stack_data_memory
  import stack_mem_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          DATA_W      = DEF_DATA_W,
  parameter int          CCR_W       = DEF_CCR_W,
  parameter int unsigned SP_INIT     = (32'd1 << ADDR_W) - 32'd1,
  parameter int unsigned STACK_LIMIT = 32'd1 << (ADDR_W - 1)
) (
  input logic                clk,
  input logic                rst,
  stack_data_memory_if.slave bus
);

`ifdef STACK_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] SP_INIT_W = ADDR_W'(SP_INIT);
  localparam logic [ADDR_W-1:0] LIMIT_W   = ADDR_W'(STACK_LIMIT);
  localparam logic [ADDR_W-1:0] SP_ONE    = ADDR_W'(1);

  state_e              state_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   sp_q;
  logic [ADDR_W-1:0]   sp_inc;
  logic [ADDR_W-1:0]   sp_dec;
  logic [2:0]          frame_op_q;
  logic [2*DATA_W-1:0] pc_q;
  logic [CCR_W-1:0]    ccr_q;
  logic [DATA_W-1:0]   lo_buf_q;
  logic [CCR_W-1:0]    ccr_buf_q;
  logic                pop_ok_q;
  logic [DATA_W-1:0]   rd_hold_q;
  logic                rd_live_q;
  logic [2*DATA_W-1:0] pc_out_q;
  logic [CCR_W-1:0]    ccr_out_q;
  logic                frame_done_q;
  logic                ovf_q;
  logic                unf_q;

  logic                push_ok;
  logic                pop_ok;
  logic [DATA_W-1:0]   pop_val;

  logic                ram_we;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_q;

  assign sp_inc  = sp_q + SP_ONE;
  assign sp_dec  = sp_q - SP_ONE;
  assign push_ok = !BOUNDS_EN || (sp_q >= LIMIT_W);
  assign pop_ok  = !BOUNDS_EN || (sp_q != SP_INIT_W);
  // A suppressed pop yields zero on the following cycle instead of stale RAM data.
  assign pop_val = pop_ok_q ? ram_q : '0;

  sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = bus.addr;
    ram_wdata = bus.wr_data;
    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          if (bus.op == OP_PUSH) begin
            ram_addr = sp_q;
            ram_we   = push_ok;
          end else if (bus.op == OP_POP) begin
            ram_addr = sp_inc;
            ram_re   = pop_ok;
          end
        end else if (bus.mem_wr) begin
          ram_we = 1'b1;
        end else if (bus.mem_rd) begin
          ram_re = 1'b1;
        end
      end
      ST_PUSH_HI: begin
        ram_addr  = sp_q;
        ram_we    = push_ok;
        ram_wdata = pc_q[2*DATA_W-1:DATA_W];
      end
      ST_PUSH_LO: begin
        ram_addr  = sp_q;
        ram_we    = push_ok;
        ram_wdata = pc_q[DATA_W-1:0];
      end
      ST_PUSH_CCR: begin
        ram_addr  = sp_q;
        ram_we    = push_ok;
        ram_wdata = DATA_W'(ccr_q);
      end
      ST_POP_0, ST_POP_1, ST_POP_2: begin
        ram_addr = sp_inc;
        ram_re   = pop_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      sp_q         <= SP_INIT_W;
      frame_op_q   <= OP_NONE;
      pc_q         <= '0;
      ccr_q        <= '0;
      lo_buf_q     <= '0;
      ccr_buf_q    <= '0;
      pop_ok_q     <= 1'b0;
      rd_hold_q    <= '0;
      rd_live_q    <= 1'b0;
      pc_out_q     <= '0;
      ccr_out_q    <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      rd_live_q    <= 1'b0;
      // Freeze the last data read so frame pops never disturb rd_data.
      if (rd_live_q) rd_hold_q <= ram_q;

      if (state_q inside {ST_PUSH_HI, ST_PUSH_LO, ST_PUSH_CCR}) begin
        if (push_ok) sp_q <= sp_dec;
        else         ovf_q <= 1'b1;
      end
      if (state_q inside {ST_POP_0, ST_POP_1, ST_POP_2}) begin
        pop_ok_q <= pop_ok;
        if (pop_ok) sp_q <= sp_inc;
        else        unf_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              OP_PUSH: begin
                if (push_ok) sp_q <= sp_dec;
                else         ovf_q <= 1'b1;
              end
              OP_POP: begin
                frame_done_q <= 1'b1;
                if (pop_ok) begin
                  sp_q      <= sp_inc;
                  rd_live_q <= 1'b1;
                end else begin
                  unf_q     <= 1'b1;
                  rd_hold_q <= '0;
                end
              end
              OP_CALL, OP_INT: begin
                frame_op_q <= bus.op;
                pc_q       <= bus.pc;
                ccr_q      <= bus.ccr;
                state_q    <= ST_PUSH_HI;
                busy_q     <= 1'b1;
              end
              OP_RET, OP_RTI: begin
                frame_op_q <= bus.op;
                state_q    <= ST_POP_0;
                busy_q     <= 1'b1;
              end
              default: ;
            endcase
          end else if (bus.mem_rd && !bus.mem_wr) begin
            rd_live_q <= 1'b1;
          end
        end
        ST_PUSH_HI: state_q <= ST_PUSH_LO;
        ST_PUSH_LO: begin
          if (frame_op_q == OP_INT) begin
            state_q <= ST_PUSH_CCR;
          end else begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        ST_PUSH_CCR: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
        end
        ST_POP_0: state_q <= ST_POP_1;
        ST_POP_1: begin
          if (frame_op_q == OP_RTI) begin
            ccr_buf_q <= pop_val[CCR_W-1:0];
            state_q   <= ST_POP_2;
          end else begin
            lo_buf_q <= pop_val;
            state_q  <= ST_CAPTURE;
          end
        end
        ST_POP_2: begin
          lo_buf_q <= pop_val;
          state_q  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          pc_out_q <= {pop_val, lo_buf_q};
          if (frame_op_q == OP_RTI) ccr_out_q <= ccr_buf_q;
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data    = rd_live_q ? ram_q : rd_hold_q;
  assign bus.pc_out     = pc_out_q;
  assign bus.ccr_out    = ccr_out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.sp_out     = sp_q;
  assign bus.stack_ovf  = BOUNDS_EN & ovf_q;
  assign bus.stack_unf  = BOUNDS_EN & unf_q;

endmodule

// File: tb/tb_stack_data_memory.sv
// Directed bench for stack_data_memory (ADDR_W=11): data ops, frames, reset abort, bounds.
module tb_stack_data_memory;
  import stack_mem_pkg::*;

  localparam int AW = 11;
  localparam int DW = 16;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   bcyc;
  int   dcnt;

  stack_data_memory_if #(.ADDR_W(AW), .DATA_W(DW), .CCR_W(CW)) bus ();

  stack_data_memory #(.ADDR_W(AW), .DATA_W(DW), .CCR_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.addr = a; bus.wr_data = d; bus.mem_wr = 1'b1;
    tick();
    bus.mem_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp_v);
    bus.addr = a; bus.mem_rd = 1'b1;
    tick();
    bus.mem_rd = 1'b0;
    chk(tag, bus.rd_data, exp_v);
  endtask

  task automatic op1(input logic [2:0] o, input logic [DW-1:0] d);
    bus.op = o; bus.wr_data = d; bus.op_valid = 1'b1;
    tick();
    clear_in();
  endtask

  task automatic frame(input logic [2:0] o, input logic [31:0] p, input logic [2:0] c,
                       output int busy_cyc, output int done_cnt);
    bus.op = o; bus.pc = p; bus.ccr = c; bus.op_valid = 1'b1;
    tick();
    clear_in();
    busy_cyc = 0;
    done_cnt = 0;
    while (bus.busy && busy_cyc < 16) begin
      if (bus.frame_done) done_cnt++;
      busy_cyc++;
      tick();
    end
    if (bus.frame_done) done_cnt++;
    chk("busy_fell", bus.busy, 0);
    tick();
    if (bus.frame_done) done_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    bus.addr = '0; bus.wr_data = '0; bus.pc = '0; bus.ccr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sp", bus.sp_out, 32'h7FF);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd", bus.rd_data, 0);
    chk("rst_done", bus.frame_done, 0);
    chk("rst_pc", bus.pc_out, 0);
    chk("rst_flags", {bus.stack_ovf, bus.stack_unf}, 0);
    rst = 1'b0;

    // plain data path
    wr(11'h010, 16'hBEEF);
    rd_chk("rd_010", 11'h010, 16'hBEEF);
    chk("rd_no_done", bus.frame_done, 0);
    tick();
    chk("rd_hold", bus.rd_data, 16'hBEEF);
    bus.addr = 11'h011; bus.wr_data = 16'h1234; bus.mem_wr = 1'b1; bus.mem_rd = 1'b1;
    tick();
    clear_in();
    chk("wr_wins_hold", bus.rd_data, 16'hBEEF);
    rd_chk("rd_011", 11'h011, 16'h1234);
    chk("sp_idle", bus.sp_out, 32'h7FF);

    // CALL / RET
    frame(OP_CALL, 32'h0001_2345, 3'd0, bcyc, dcnt);
    chk("call_busy", bcyc, 2);
    chk("call_done", dcnt, 1);
    chk("call_sp", bus.sp_out, 32'h7FD);
    rd_chk("call_hi", 11'h7FF, 16'h0001);
    rd_chk("call_lo", 11'h7FE, 16'h2345);
    frame(OP_RET, 32'h0, 3'd0, bcyc, dcnt);
    chk("ret_busy", bcyc, 3);
    chk("ret_done", dcnt, 1);
    chk("ret_pc", bus.pc_out, 32'h0001_2345);
    chk("ret_sp", bus.sp_out, 32'h7FF);
    chk("ret_rd_hold", bus.rd_data, 16'h2345);

    // INT / RTI
    frame(OP_INT, 32'h0000_0ABC, 3'b101, bcyc, dcnt);
    chk("int_busy", bcyc, 3);
    chk("int_sp", bus.sp_out, 32'h7FC);
    rd_chk("int_ccr_word", 11'h7FD, 16'h0005);
    frame(OP_RTI, 32'h0, 3'd0, bcyc, dcnt);
    chk("rti_busy", bcyc, 4);
    chk("rti_done", dcnt, 1);
    chk("rti_ccr", bus.ccr_out, 3'b101);
    chk("rti_pc", bus.pc_out, 32'h0000_0ABC);
    chk("rti_sp", bus.sp_out, 32'h7FF);

    // single PUSH / POP
    op1(OP_PUSH, 16'hA5A5);
    chk("push_sp", bus.sp_out, 32'h7FE);
    chk("push_busy", bus.busy, 0);
    op1(OP_POP, 16'h0);
    chk("pop_rd", bus.rd_data, 16'hA5A5);
    chk("pop_done", bus.frame_done, 1);
    chk("pop_sp", bus.sp_out, 32'h7FF);
    tick();
    chk("pop_done_pulse", bus.frame_done, 0);
    chk("pop_rd_hold", bus.rd_data, 16'hA5A5);

    // reset during the second cycle of INT
    bus.op = OP_INT; bus.pc = 32'h1111_2222; bus.ccr = 3'b011; bus.op_valid = 1'b1;
    tick();
    clear_in();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_sp", bus.sp_out, 32'h7FF);
    chk("mid_rst_done", bus.frame_done, 0);
    chk("mid_rst_pc", bus.pc_out, 0);
    #1 rst = 1'b0;
    dcnt = 0;
    repeat (3) begin
      tick();
      if (bus.frame_done) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);
    frame(OP_CALL, 32'hCAFE_0001, 3'd0, bcyc, dcnt);
    chk("post_rst_call_busy", bcyc, 2);
    chk("post_rst_call_sp", bus.sp_out, 32'h7FD);
    frame(OP_RET, 32'h0, 3'd0, bcyc, dcnt);
    chk("post_rst_ret_pc", bus.pc_out, 32'hCAFE_0001);
    chk("post_rst_flags", {bus.stack_ovf, bus.stack_unf}, 0);

`ifdef STACK_BOUNDS_CHECK_EN
    op1(OP_POP, 16'h0);
    chk("unf_flag", bus.stack_unf, 1);
    chk("unf_sp", bus.sp_out, 32'h7FF);
    chk("unf_rd", bus.rd_data, 0);
    chk("unf_done", bus.frame_done, 1);
    chk("unf_no_ovf", bus.stack_ovf, 0);
    wr(11'h3FF, 16'h1111);
    bus.op = OP_PUSH; bus.op_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      bus.wr_data = 16'(i);
      tick();
    end
    clear_in();
    chk("fill_sp", bus.sp_out, 32'h3FF);
    chk("fill_no_ovf", bus.stack_ovf, 0);
    op1(OP_PUSH, 16'hDEAD);
    chk("ovf_flag", bus.stack_ovf, 1);
    chk("ovf_sp", bus.sp_out, 32'h3FF);
    rd_chk("ovf_no_write", 11'h3FF, 16'h1111);
    rd_chk("last_push", 11'h400, 16'h03FF);
    frame(OP_CALL, 32'h1234_5678, 3'd0, bcyc, dcnt);
    chk("ovf_call_busy", bcyc, 2);
    chk("ovf_call_done", dcnt, 1);
    chk("ovf_call_sp", bus.sp_out, 32'h3FF);
    chk("unf_sticky", bus.stack_unf, 1);
`else
    op1(OP_POP, 16'h0);
    chk("wrap_pop_sp", bus.sp_out, 32'h000);
    chk("wrap_flags", {bus.stack_ovf, bus.stack_unf}, 0);
    op1(OP_PUSH, 16'h5555);
    chk("wrap_push_sp", bus.sp_out, 32'h7FF);
    rd_chk("wrap_push_data", 11'h000, 16'h5555);
    chk("wrap_flags_end", {bus.stack_ovf, bus.stack_unf}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_data_memory.md
Name: stack_data_memory

Overview:
- Parametrised successor of the pipeline's data-memory stage: a single-port synchronous data RAM with a hardware stack-pointer unit.
- A frame sequencer turns one CALL/RET/INT/RTI request into a multi-cycle push/pop of PC halves and CCR, stalling the pipeline via busy.
- Adds sticky overflow/underflow detection.
- Sits in the MEM stage and is driven by the EX/MEM register.

Parameters:
- ADDR_W, 12, address width; memory depth is 2**ADDR_W words.
- DATA_W, 16, word width; the PC is 2*DATA_W bits.
- CCR_W, 3, condition-code width; zero-extended into one word.
- SP_INIT, 2**ADDR_W-1, SP value after reset (empty stack, top word).
- STACK_LIMIT, 2**(ADDR_W-1), lowest legal stack address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  stack/frame request strobe; sampled only when busy=0.
- op  in  3  0 NONE, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 INT, 6 RTI.
- mem_rd  in  1  data read at addr (op NONE only).
- mem_wr  in  1  data write of wr_data at addr (op NONE only).
- addr  in  ADDR_W  data address.
- wr_data  in  DATA_W  ALU result / PUSH data.
- pc  in  2*DATA_W  PC to save.
- ccr  in  CCR_W  flags to save.
- rd_data  out  DATA_W  read/POP data.
- pc_out  out  2*DATA_W  restored PC.
- ccr_out  out  CCR_W  restored CCR.
- frame_done  out  1  one-cycle pulse: rd_data/pc_out/ccr_out valid.
- busy  out  1  sequencer active; pipeline stalls.
- sp_out  out  ADDR_W  current SP.
- stack_ovf  out  1  sticky overflow.
- stack_unf  out  1  sticky underflow.

Behaviour:
- Reset (async): SP=SP_INIT; FSM=IDLE; all outputs 0. RAM contents are not cleared.
- Stack convention: empty-descending.
  - Push: mem[SP]<=word; SP<=SP-1.
  - Pop: SP<=SP+1; read mem[SP+1].
- RAM read latency is 1 cycle. rd_data is registered and holds between reads.
- IDLE data ops:
  - mem_wr writes next edge.
  - mem_rd gives rd_data on the following cycle, with no frame_done.
  - mem_rd and mem_wr together: write wins; rd_data holds.
  - mem_rd/mem_wr are ignored when op_valid=1 or busy=1.
- PUSH: 1 cycle, busy stays 0.
- POP: 1 cycle. rd_data and a frame_done pulse appear on the next cycle; busy stays 0.
- Sequencer states: IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, POP_0, POP_1, POP_2, CAPTURE. busy=1 in every state except IDLE.
- CALL: PUSH_HI (pc[2*DATA_W-1:DATA_W]) -> PUSH_LO -> IDLE. busy for 2 cycles; frame_done pulses on the final edge.
- INT: PUSH_HI -> PUSH_LO -> PUSH_CCR (zero-extended ccr) -> IDLE. busy for 3 cycles.
- RET: POP_0 (lo) -> POP_1 (hi) -> CAPTURE -> IDLE. pc_out is updated at CAPTURE with frame_done. busy for 3 cycles.
- RTI: POP_0 (ccr) -> POP_1 (lo) -> POP_2 (hi) -> CAPTURE. busy for 4 cycles; ccr_out and pc_out are updated together.
- A new op_valid while busy is ignored; the issuer holds it until busy falls.
- Overflow: a push with SP<STACK_LIMIT is suppressed (no write, SP unchanged) and sets stack_ovf. The sequence still completes its remaining steps.
- Underflow: a pop with SP==SP_INIT is suppressed (SP unchanged, data 0) and sets stack_unf.
- Flags clear only on reset.
- SP arithmetic is ADDR_W bits.
- Reset mid-sequence: immediate IDLE; partial frame abandoned; no frame_done.

Optional Feature:
- STACK_BOUNDS_CHECK_EN defined: overflow/underflow checks and suppression as above.
- Undefined: no checks; SP wraps modulo 2**ADDR_W; stack_ovf and stack_unf tied 0.

Decomposition:
- Package stack_mem_pkg: op encoding constants, FSM state enum, default width constants.
- One sub-module, sp_ram: single-port synchronous RAM with parameters ADDR_W and DATA_W, 1-cycle registered read. All stack/FSM logic stays in the top module.

Test Plan:
- Reset, then mem_wr addr=0x010 data=0xBEEF; next mem_rd addr=0x010 -> rd_data=0xBEEF one cycle later; sp_out=0x7FF.
- CALL pc=0x0001_2345 then RET -> busy 2 then 3 cycles; mem[0x7FF]=0x0001, mem[0x7FE]=0x2345; pc_out=0x00012345; sp_out back to 0x7FF.
- INT pc=0x0000_0ABC ccr=3'b101 then RTI -> ccr_out=3'b101, pc_out=0x00000ABC; single frame_done after 4 busy cycles.
- POP on an empty stack (bounds check on) -> stack_unf=1, sp_out stays 0x7FF, rd_data=0. Push until SP=0x3FF, then push -> stack_ovf=1, no write.
- Assert rst during the second cycle of INT -> busy=0, sp_out=0x7FF immediately, no frame_done; a following CALL works normally.
- With STACK_BOUNDS_CHECK_EN undefined: POP at SP=0x7FF -> sp_out=0x000, flags stay 0.
